y86_bus_mem: RTL

Byte-addressable memory and I/O slave sitting directly on the y86 sequential core's bus. It consumes the core's bus_A / bus_out / bus_WE / bus_RE and produces the word the core samples on its bus_in. Serves unaligned little-endian 32-bit instruction fetches and loads combinationally, and commits stores synchronously. Also hosts a small memory-mapped I/O page with a transmit byte queue and a cycle counter.

---
 rtl/y86_pkg.sv | 16 +
 rtl/y86_bus_mem_if.sv | 24 ++
 rtl/y86_txq.sv | 100 ++++++++++
 rtl/y86_bus_mem.sv | 137 +++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared constants for the y86 bus memory/I-O slave: I/O page select,
// register byte offsets inside the page, and STATUS bit positions.
package y86_pkg;

   localparam logic [23:0] IO_PAGE    = 24'hFFFFFF;

   localparam logic [7:0]  OFS_TXDATA = 8'h00;
   localparam logic [7:0]  OFS_STATUS = 8'h04;
   localparam logic [7:0]  OFS_CYCLES = 8'h08;

   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_OVF     = 2;
   localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/y86_bus_mem_if.sv
// Bus between the y86 sequential core (master) and the memory/I-O slave,
// plus the transmit-byte stream offered by the slave to a consumer.
interface y86_bus_mem_if;

   logic [31:0] bus_A;
   logic [31:0] bus_wdata;
   logic        bus_WE;
   logic        bus_RE;
   logic [31:0] bus_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output bus_A, bus_wdata, bus_WE, bus_RE, tx_ready,
      input  bus_rdata, tx_data, tx_valid
   );

   modport slave (
      input  bus_A, bus_wdata, bus_WE, bus_RE, tx_ready,
      output bus_rdata, tx_data, tx_valid
   );

endinterface

// File: rtl/y86_txq.sv
// Transmit byte FIFO with a registered head byte and a sticky overflow flag.
// A push into a full queue is still accepted when a pop happens in the same
// cycle; otherwise it is dropped and overflow is raised.
module y86_txq #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [7:0]                 push_data,
   input  logic                       tx_ready,
   input  logic                       ovf_clr,
   output logic [7:0]                 head,
   output logic                       valid,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    fifo_q [DEPTH];
   logic [7:0]    fifo_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    head_q, head_d;
   logic          ovf_q, ovf_d;
   logic          pop;
   logic          push_ok;

   // Next-state for storage, pointers, occupancy, head byte and overflow.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      head_d   = 8'h00;

      pop     = (count_q != '0) && tx_ready;
      push_ok = push && ((count_q != CW'(DEPTH)) || pop);

      if (push_ok) begin
         fifo_d[wr_ptr_q] = push_data;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (push && !push_ok) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end

      if (count_d != '0) begin
         if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
         end else begin
            head_d = fifo_q[rd_ptr_d];
         end
      end
   end

   // Register update; reset empties the queue but leaves storage contents alone.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= 8'h00;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         ovf_q    <= ovf_d;
      end
   end

   assign head     = head_q;
   assign valid    = (count_q != '0);
   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign overflow = ovf_q;
   assign count    = count_q;

endmodule

// File: rtl/y86_bus_mem.sv
// Byte-addressable RAM plus a small I/O page (TX queue, STATUS, CYCLES) on
// the y86 core bus. Reads are combinational and unaligned with wrap-around;
// stores commit at the clock edge. Define Y86_CYCLE_CNT_EN to include the
// free-running CYCLES counter; without it offset 0x08 reads 0.
module y86_bus_mem
   import y86_pkg::*;
#(
   parameter int ADDR_BITS = 12,
   parameter int TXQ_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   y86_bus_mem_if.slave  bus
);

   localparam int RAM_BYTES = 2 ** ADDR_BITS;
   localparam int CNT_W     = $clog2(TXQ_DEPTH) + 1;

   logic [7:0]           ram_q [RAM_BYTES];
   logic [ADDR_BITS-1:0] lane_addr [4];
   logic                 io_sel;
   logic [7:0]           io_ofs;
   logic                 io_we;
   logic                 ram_we;
   logic                 txq_push;
   logic                 ovf_clr;
   logic [31:0]          ram_rdata;
   logic [31:0]          status_word;
   logic [31:0]          cycles_rd;
   logic [31:0]          rdata;
   logic [7:0]           tx_head;
   logic                 tx_valid_w;
   logic                 q_full;
   logic                 q_empty;
   logic                 q_overflow;
   logic [CNT_W-1:0]     q_count;

   // Address decode: I/O page versus RAM, register offset, byte-lane addresses.
   always_comb begin
      io_sel   = (bus.bus_A[31:8] == IO_PAGE);
      io_ofs   = {bus.bus_A[7:2], 2'b00};
      io_we    = bus.bus_WE && io_sel;
      ram_we   = bus.bus_WE && !io_sel;
      txq_push = io_we && (io_ofs == OFS_TXDATA);
      ovf_clr  = io_we && (io_ofs == OFS_STATUS);
      for (int i = 0; i < 4; i++) begin
         lane_addr[i] = bus.bus_A[ADDR_BITS-1:0] + ADDR_BITS'(i);
      end
   end

   // Little-endian unaligned RAM read; lane addresses wrap at the top of RAM.
   always_comb begin
      ram_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         ram_rdata[8*i +: 8] = ram_q[lane_addr[i]];
      end
   end

   // RAM store commits at the edge, also during reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            ram_q[lane_addr[i]] <= bus.bus_wdata[8*i +: 8];
         end
      end
   end

   y86_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
      .clk       (clk),
      .rst       (rst),
      .push      (txq_push),
      .push_data (bus.bus_wdata[7:0]),
      .tx_ready  (bus.tx_ready),
      .ovf_clr   (ovf_clr),
      .head      (tx_head),
      .valid     (tx_valid_w),
      .full      (q_full),
      .empty     (q_empty),
      .overflow  (q_overflow),
      .count     (q_count)
   );

   // STATUS register image assembled from the queue flags.
   always_comb begin
      status_word                       = '0;
      status_word[STAT_FULL]            = q_full;
      status_word[STAT_EMPTY]           = q_empty;
      status_word[STAT_OVF]             = q_overflow;
      status_word[STAT_CNT_LSB +: 4]    = 4'(q_count);
   end

`ifdef Y86_CYCLE_CNT_EN
   logic [31:0] cycles_q, cycles_d;

   // Free-running cycle counter; a write loads it, otherwise it increments.
   always_comb begin
      cycles_d = cycles_q + 32'd1;
      if (io_we && (io_ofs == OFS_CYCLES)) begin
         cycles_d = bus.bus_wdata;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycles_q <= '0;
      end else begin
         cycles_q <= cycles_d;
      end
   end

   assign cycles_rd = cycles_q;
`else
   assign cycles_rd = '0;
`endif

   // Read mux: zero unless reading; I/O registers or RAM otherwise.
   always_comb begin
      rdata = '0;
      if (bus.bus_RE) begin
         if (io_sel) begin
            case (io_ofs)
               OFS_STATUS: rdata = status_word;
               OFS_CYCLES: rdata = cycles_rd;
               default:    rdata = '0;
            endcase
         end else begin
            rdata = ram_rdata;
         end
      end
   end

   assign bus.bus_rdata = rdata;
   assign bus.tx_data   = tx_head;
   assign bus.tx_valid  = tx_valid_w;

endmodule
